// File: rtl/io_uart.sv
`timescale 1ns/1ps
// io_uart: 8-bit UART with an RX FIFO and a single-byte TX path.
//
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   uart_rxd     asynchronous serial input (idle high)
//   uart_txd     registered serial output (idle high)
//   io_in_*      valid/ready stream out of the RX FIFO
//   io_out_*     valid/ready stream into the transmitter
//   io_err       sticky {any, parity, frame, overrun, lost}; cleared by a pop
module io_uart #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic [7:0] io_in_data,
   output logic       io_in_vld,
   input  logic       io_in_rdy,
   input  logic [7:0] io_out_data,
   input  logic       io_out_vld,
   output logic       io_out_rdy,
   output logic [4:0] io_err
);

   localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT);
   localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
   localparam logic [AW:0] DEPTH    = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
   } rx_state_t;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   logic        sync1_q, sync1_d, sync2_q, sync2_d;
   logic        rxd_s;

   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_bad_q, rx_bad_d;
   logic        rx_tick, push_req;
   logic        set_lost, set_frame, set_parity, set_overrun;

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic        pop, push_ok;
   logic [3:0]  err_q, err_d;

   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        tx_par_q, tx_par_d;
   logic        txd_q, txd_d;
   logic        tx_tick;

   // Two-flop synchronizer; idles high so a reset never looks like a start bit.
   always_comb begin
      sync1_d = uart_rxd;
      sync2_d = sync1_q;
   end

   assign rxd_s = sync2_q;

   // Bit timers count down from the load value and fire when they reach 1, so a
   // load of N gives exactly N cycles. The start bit uses half a bit so that
   // later samples land near the middle of each bit.
   assign rx_tick = (rx_cnt_q == 16'd1);
   assign tx_tick = (tx_cnt_q == 16'd1);

   // Receiver: hunt for a start bit, confirm it mid-bit, shift in LSB first,
   // optionally check even parity, then judge the stop bit.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_bad_d   = rx_bad_q;
      push_req   = 1'b0;
      set_lost   = 1'b0;
      set_frame  = 1'b0;
      set_parity = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rxd_s) begin
               rx_state_d = RX_START;
               rx_cnt_d   = HALF_CNT;
               rx_bad_d   = 1'b0;
            end
         end
         RX_START: begin
            if (rx_tick) begin
               if (!rxd_s) begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = BIT_CNT;
                  rx_bit_d   = 3'd0;
               end else begin
                  set_lost   = 1'b1;
                  rx_state_d = RX_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_shift_d = {rxd_s, rx_shift_q[7:1]};
               rx_cnt_d   = BIT_CNT;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_PARITY: begin
            if (rx_tick) begin
               if ((^rx_shift_q) != rxd_s) begin
                  set_parity = 1'b1;
                  rx_bad_d   = 1'b1;
               end
               rx_cnt_d   = BIT_CNT;
               rx_state_d = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               if (rxd_s) begin
                  push_req   = !rx_bad_q;
                  rx_state_d = RX_IDLE;
               end else begin
                  set_frame  = 1'b1;
                  rx_state_d = RX_WAIT_HIGH;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end
         end
         RX_WAIT_HIGH: begin
            if (rxd_s) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // RX FIFO: a full FIFO still accepts a push when the head leaves in the
   // same cycle. Error flags clear on a pop, but a new error raised in that
   // cycle survives the clear.
   always_comb begin
      pop         = (count_q != '0) && io_in_rdy;
      push_ok     = push_req && ((count_q < DEPTH) || pop);
      set_overrun = push_req && !push_ok;
      mem_d       = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = rx_shift_q;
      end
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      err_d    = pop ? 4'd0 : err_q;
      err_d    = err_d | {set_parity, set_frame, set_overrun, set_lost};
   end

   assign io_in_data = mem_q[rd_ptr_q];
   assign io_in_vld  = (count_q != '0);
   assign io_err     = {|err_q, err_q};

   // Transmitter: the line level for the next bit is decided here and
   // registered, so uart_txd comes straight from a flop.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      txd_d      = txd_q;
      case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (io_out_vld) begin
               tx_shift_d = io_out_data;
               tx_par_d   = ^io_out_data;
               tx_cnt_d   = BIT_CNT;
               txd_d      = 1'b0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_tick) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = BIT_CNT;
               tx_bit_d   = 3'd0;
               txd_d      = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               tx_cnt_d = BIT_CNT;
               if (tx_bit_q == 3'd7) begin
                  if (PARITY_EN != 0) begin
                     tx_state_d = TX_PARITY;
                     txd_d      = tx_par_q;
                  end else begin
                     tx_state_d = TX_STOP;
                     txd_d      = 1'b1;
                  end
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  txd_d      = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_PARITY: begin
            if (tx_tick) begin
               tx_state_d = TX_STOP;
               tx_cnt_d   = BIT_CNT;
               txd_d      = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_tick) begin
               tx_state_d = TX_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign uart_txd   = txd_q;
   assign io_out_rdy = (tx_state_q == TX_IDLE);

   // State registers; reset abandons any frame in flight on either side.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= 16'd0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
         rx_bad_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_q      <= 4'd0;
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= 16'd0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'd0;
         tx_par_q   <= 1'b0;
         txd_q      <= 1'b1;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_bad_q   <= rx_bad_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_q      <= err_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         txd_q      <= txd_d;
      end
   end

   // FIFO storage needs no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_io_uart.sv
`timescale 1ns/1ps
// tb_io_uart: directed testbench for io_uart at CLKS_PER_BIT=4, no parity.
module tb_io_uart;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_rxd = 1'b1;
   logic       uart_txd;
   logic [7:0] io_in_data;
   logic       io_in_vld;
   logic       io_in_rdy = 1'b0;
   logic [7:0] io_out_data = 8'h00;
   logic       io_out_vld = 1'b0;
   logic       io_out_rdy;
   logic [4:0] io_err;

   int checks = 0;
   int passed = 0;

   io_uart #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(16),
      .PARITY_EN(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .uart_rxd(uart_rxd),
      .uart_txd(uart_txd),
      .io_in_data(io_in_data),
      .io_in_vld(io_in_vld),
      .io_in_rdy(io_in_rdy),
      .io_out_data(io_out_data),
      .io_out_vld(io_out_vld),
      .io_out_rdy(io_out_rdy),
      .io_err(io_err)
   );

   // 100 MHz clock; stimulus changes and sampling happen on the falling edge.
   always #5 clk = ~clk;

   // Drives one serial frame onto uart_rxd, starting and ending on a falling edge.
   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   // Brings the DUT back to a clean state between scenarios.
   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      io_out_vld = 1'b0;
      io_in_rdy  = 1'b0;
      uart_rxd   = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Reset state, with io_out_vld and a low uart_rxd ignored during reset.
   task automatic test_reset();
      io_out_vld  = 1'b1;
      io_out_data = 8'hFF;
      uart_rxd    = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (uart_txd !== 1'b1) $display("[TB] FAIL reset_txd: got %b expected 1", uart_txd);
      else passed++;
      checks++;
      if (io_out_rdy !== 1'b1) $display("[TB] FAIL reset_rdy: got %b expected 1", io_out_rdy);
      else passed++;
      checks++;
      if (io_in_vld !== 1'b0) $display("[TB] FAIL reset_vld: got %b expected 0", io_in_vld);
      else passed++;
      checks++;
      if (io_err !== 5'b00000) $display("[TB] FAIL reset_err: got %b expected 00000", io_err);
      else passed++;
      io_out_vld = 1'b0;
      uart_rxd   = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (io_out_rdy !== 1'b1 || uart_txd !== 1'b1)
         $display("[TB] FAIL reset_release: got rdy=%b txd=%b expected rdy=1 txd=1", io_out_rdy, uart_txd);
      else passed++;
      checks++;
      if (io_in_vld !== 1'b0) $display("[TB] FAIL reset_release_vld: got %b expected 0", io_in_vld);
      else passed++;
   endtask

   // One clean byte received, then popped.
   task automatic test_rx_byte();
      rx_send(8'hA5, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (io_in_vld !== 1'b1) $display("[TB] FAIL rx_vld: got %b expected 1", io_in_vld);
      else passed++;
      checks++;
      if (io_in_data !== 8'hA5) $display("[TB] FAIL rx_data: got %h expected a5", io_in_data);
      else passed++;
      checks++;
      if (io_err !== 5'b00000) $display("[TB] FAIL rx_err: got %b expected 00000", io_err);
      else passed++;
      io_in_rdy = 1'b1;
      @(negedge clk);
      io_in_rdy = 1'b0;
      checks++;
      if (io_in_vld !== 1'b0) $display("[TB] FAIL rx_pop_vld: got %b expected 0", io_in_vld);
      else passed++;
   endtask

   // Transmit 0x3C and follow the line and io_out_rdy cycle by cycle.
   task automatic test_tx();
      logic [9:0] exp_line;
      exp_line    = 10'b1001111000;
      io_out_data = 8'h3C;
      io_out_vld  = 1'b1;
      @(negedge clk);
      io_out_vld = 1'b0;
      for (int i = 0; i < 10 * CPB; i++) begin
         checks++;
         if (uart_txd !== exp_line[i / CPB])
            $display("[TB] FAIL tx_line[%0d]: got %b expected %b", i, uart_txd, exp_line[i / CPB]);
         else passed++;
         checks++;
         if (io_out_rdy !== 1'b0)
            $display("[TB] FAIL tx_rdy_busy[%0d]: got %b expected 0", i, io_out_rdy);
         else passed++;
         @(negedge clk);
      end
      checks++;
      if (io_out_rdy !== 1'b1 || uart_txd !== 1'b1)
         $display("[TB] FAIL tx_done: got rdy=%b txd=%b expected rdy=1 txd=1", io_out_rdy, uart_txd);
      else passed++;
   endtask

   // Seventeen bytes into a 16-entry FIFO with nobody reading.
   task automatic test_overrun();
      do_reset();
      for (int b = 0; b < 17; b++) begin
         rx_send(8'(b), 1'b1);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (io_err !== 5'b10010) $display("[TB] FAIL ovr_err: got %b expected 10010", io_err);
      else passed++;
      io_in_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (io_in_vld !== 1'b1 || io_in_data !== 8'(i))
            $display("[TB] FAIL ovr_drain[%0d]: got vld=%b data=%h expected vld=1 data=%h",
                     i, io_in_vld, io_in_data, 8'(i));
         else passed++;
         @(negedge clk);
      end
      io_in_rdy = 1'b0;
      checks++;
      if (io_in_vld !== 1'b0) $display("[TB] FAIL ovr_empty: got %b expected 0", io_in_vld);
      else passed++;
      checks++;
      if (io_err !== 5'b00000) $display("[TB] FAIL ovr_err_clear: got %b expected 00000", io_err);
      else passed++;
   endtask

   // Stop bit low, then the line held low: frame error, no push, no restart.
   task automatic test_frame_error();
      do_reset();
      rx_send(8'h55, 1'b0);
      uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (io_err !== 5'b10100) $display("[TB] FAIL frame_err: got %b expected 10100", io_err);
      else passed++;
      checks++;
      if (io_in_vld !== 1'b0) $display("[TB] FAIL frame_nopush: got %b expected 0", io_in_vld);
      else passed++;
      repeat (27) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (50) @(negedge clk);
      checks++;
      if (io_in_vld !== 1'b0) $display("[TB] FAIL frame_wait_high: got vld=%b expected 0", io_in_vld);
      else passed++;
      checks++;
      if (io_err !== 5'b10100) $display("[TB] FAIL frame_err_sticky: got %b expected 10100", io_err);
      else passed++;
      rx_send(8'h5A, 1'b1);
      repeat (2) @(negedge clk);
      checks++;
      if (io_in_vld !== 1'b1 || io_in_data !== 8'h5A)
         $display("[TB] FAIL frame_recover: got vld=%b data=%h expected vld=1 data=5a", io_in_vld, io_in_data);
      else passed++;
   endtask

   // A two-cycle low pulse is not a start bit.
   task automatic test_glitch();
      do_reset();
      uart_rxd = 1'b0;
      repeat (2) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (io_err !== 5'b10001) $display("[TB] FAIL glitch_err: got %b expected 10001", io_err);
      else passed++;
      checks++;
      if (io_in_vld !== 1'b0) $display("[TB] FAIL glitch_nopush: got %b expected 0", io_in_vld);
      else passed++;
   endtask

   // Reset in the middle of data bit 3, then a fresh transmission of 0xA5.
   task automatic test_reset_mid_tx();
      logic [9:0] exp_line;
      int         low_seen;
      do_reset();
      io_out_data = 8'hC3;
      io_out_vld  = 1'b1;
      @(negedge clk);
      io_out_vld = 1'b0;
      repeat (17) @(negedge clk);
      checks++;
      if (uart_txd !== 1'b0) $display("[TB] FAIL midtx_bit3: got %b expected 0", uart_txd);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (uart_txd !== 1'b1 || io_out_rdy !== 1'b1)
         $display("[TB] FAIL midtx_reset: got txd=%b rdy=%b expected txd=1 rdy=1", uart_txd, io_out_rdy);
      else passed++;
      rst = 1'b0;
      low_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (uart_txd !== 1'b1) low_seen++;
      end
      checks++;
      if (low_seen != 0) $display("[TB] FAIL midtx_quiet: got %0d low cycles expected 0", low_seen);
      else passed++;
      exp_line    = 10'b1101001010;
      io_out_data = 8'hA5;
      io_out_vld  = 1'b1;
      @(negedge clk);
      io_out_vld = 1'b0;
      for (int i = 0; i < 10 * CPB; i++) begin
         checks++;
         if (uart_txd !== exp_line[i / CPB] || io_out_rdy !== 1'b0)
            $display("[TB] FAIL midtx_resend[%0d]: got txd=%b rdy=%b expected txd=%b rdy=0",
                     i, uart_txd, io_out_rdy, exp_line[i / CPB]);
         else passed++;
         @(negedge clk);
      end
      checks++;
      if (io_out_rdy !== 1'b1) $display("[TB] FAIL midtx_resend_done: got %b expected 1", io_out_rdy);
      else passed++;
   endtask

   initial begin
      $display("[TB] io_uart directed test start");
      test_reset();
      test_rx_byte();
      test_tx();
      test_overrun();
      test_frame_error();
      test_glitch();
      test_reset_mid_tx();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
